// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared constants and helpers for the restoring divider
//                (controller wrapper and datapath).
//  Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    // Default operand / result width.
    localparam int DIV_W = 8;

    // Counter value at which the last iteration cycle is in progress.
    localparam int DIV_MAX_CNT = DIV_W - 1;

    // Iteration counter width: must hold the value N itself (saturation point).
    function automatic int div_cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_iter_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : div_iter_cnt
//  Description : Iteration counter for the restoring divider. Cleared by load
//                or by the active-low synchronous clear, counts shift cycles
//                and saturates at N. Decodes max (last iteration in progress)
//                and res_valid (all N iterations done).
//  Revision    : 1.0 - initial release
// ============================================================================
module div_iter_cnt
    import div_pkg::*;
#(
    parameter int N  = DIV_W,
    parameter int CW = div_cnt_w(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic          i_prst,
    input  logic          i_shift,
    output logic [CW-1:0] o_count,
    output logic          o_active,
    output logic          o_max,
    output logic          o_res_valid
);

    localparam logic [CW-1:0] C_LAST = CW'(N - 1);
    localparam logic [CW-1:0] C_DONE = CW'(N);

    logic [CW-1:0] r_count;

    // Counter: load and sync clear restart it; shifts advance it until N.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_load || !i_prst) begin
            r_count <= '0;
        end else if (i_shift && (r_count < C_DONE)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count     = r_count;
    assign o_active    = (r_count < C_DONE);
    assign o_max       = (r_count == C_LAST);
    assign o_res_valid = (r_count == C_DONE);

endmodule : div_iter_cnt
`default_nettype wire

// File: rtl/div_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : div_datapath
//  Description : Sequential restoring-division datapath for unsigned N-bit
//                operands. Driven by the divider controller through load,
//                shift and prst; returns max so the controller shifts for
//                exactly N cycles. A divisor of zero is not special-cased:
//                the arithmetic yields all-ones quotient and remainder equal
//                to the dividend, and div_by_zero flags it.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_datapath
    import div_pkg::*;
#(
    parameter int N  = DIV_W,
    parameter int CW = div_cnt_w(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic         prst,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         max,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero,
    output logic         res_valid
);

    logic [N:0]    r_a;     // partial remainder
    logic [N-1:0]  r_q;     // dividend shifting out / quotient shifting in
    logic [N-1:0]  r_m;     // divisor
    logic          r_dbz;

    logic [CW-1:0] w_count;
    logic          w_active;
    logic [N:0]    w_shifted;
    logic [N:0]    w_trial;
    logic          w_step;
    logic          w_unused;

    div_iter_cnt #(
        .N  (N),
        .CW (CW)
    ) u_cnt (
        .clk         (clk),
        .rst         (rst),
        .i_load      (load),
        .i_prst      (prst),
        .i_shift     (shift),
        .o_count     (w_count),
        .o_active    (w_active),
        .o_max       (max),
        .o_res_valid (res_valid)
    );

    // Trial subtraction of the divisor from the shifted partial remainder.
    assign w_shifted = {r_a[N-1:0], r_q[N-1]};
    assign w_trial   = w_shifted - {1'b0, r_m};

    // An iteration happens only when neither load nor the clear takes priority
    // and the counter has not yet saturated, so extra shifts leave the result.
    assign w_step    = !load && prst && shift && w_active;

    // The top bit of A only holds a transient borrow and is never read back.
    assign w_unused  = &{1'b0, r_a[N], w_count};

    // Operand capture and one restoring iteration per enabled shift cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a   <= '0;
            r_q   <= '0;
            r_m   <= '0;
            r_dbz <= 1'b0;
        end else if (load) begin
            r_a   <= '0;
            r_q   <= dividend;
            r_m   <= divisor;
            r_dbz <= (divisor == '0);
        end else if (w_step) begin
            if (w_trial[N]) begin
                r_a <= w_shifted;
                r_q <= {r_q[N-2:0], 1'b0};
            end else begin
                r_a <= w_trial;
                r_q <= {r_q[N-2:0], 1'b1};
            end
        end
    end

    assign quotient    = r_q;
    assign remainder   = r_a[N-1:0];
    assign div_by_zero = r_dbz;

endmodule : div_datapath
`default_nettype wire

// File: tb/tb_div_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_datapath
//  Description : Self-checking bench for div_datapath. Expected results come
//                from plain integer division in the bench.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_datapath;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic         shift;
    logic         prst;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         max;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;
    logic         res_valid;

    int n_vec = 0;
    int n_err = 0;

    div_datapath #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .shift       (shift),
        .prst        (prst),
        .dividend    (dividend),
        .divisor     (divisor),
        .max         (max),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .res_valid   (res_valid)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of controls, then settle just after the rising edge.
    task automatic cyc(input logic ld, input logic sh, input logic pr,
                       input logic [N-1:0] dd, input logic [N-1:0] dv);
        load     = ld;
        shift    = sh;
        prst     = pr;
        dividend = dd;
        divisor  = dv;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] ref_q(input int a, input int b);
        return (b == 0) ? {N{1'b1}} : N'(a / b);
    endfunction

    function automatic logic [N-1:0] ref_r(input int a, input int b);
        return (b == 0) ? N'(a) : N'(a % b);
    endfunction

    // Load (optionally with a simultaneous shift) followed by N shift cycles;
    // checks max timing and the final result. Operand inputs are scrambled
    // during shifting to confirm they are only sampled on load.
    task automatic run_div(input int a, input int b, input logic ld_shift, input string tag);
        cyc(1'b1, ld_shift, 1'b1, N'(a), N'(b));
        check_val({tag, ".valid_after_load"}, 32'(res_valid), 32'd0);
        for (int i = 0; i < N; i++) begin
            check_val({tag, ".max"}, 32'(max), (i == N - 1) ? 32'd1 : 32'd0);
            cyc(1'b0, 1'b1, 1'b1, N'($urandom), N'($urandom));
        end
        check_val({tag, ".max_done"},  32'(max),         32'd0);
        check_val({tag, ".quotient"},  32'(quotient),    32'(ref_q(a, b)));
        check_val({tag, ".remainder"}, 32'(remainder),   32'(ref_r(a, b)));
        check_val({tag, ".dbz"},       32'(div_by_zero), (b == 0) ? 32'd1 : 32'd0);
        check_val({tag, ".res_valid"}, 32'(res_valid),   32'd1);
    endtask

    initial begin
        int a;
        int b;
        rst = 1'b0;
        load = 1'b0; shift = 1'b0; prst = 1'b1;
        dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst.quotient",  32'(quotient),    32'd0);
        check_val("rst.remainder", 32'(remainder),   32'd0);
        check_val("rst.dbz",       32'(div_by_zero), 32'd0);
        check_val("rst.max",       32'(max),         32'd0);
        check_val("rst.res_valid", 32'(res_valid),   32'd0);
        rst = 1'b1;

        // Asynchronous reset in the middle of a division.
        cyc(1'b1, 1'b0, 1'b1, 8'd100, 8'd7);
        repeat (3) cyc(1'b0, 1'b1, 1'b1, 8'd0, 8'd0);
        #2 rst = 1'b0;
        #1;
        check_val("midrst.quotient",  32'(quotient),  32'd0);
        check_val("midrst.remainder", 32'(remainder), 32'd0);
        check_val("midrst.max",       32'(max),       32'd0);
        check_val("midrst.res_valid", 32'(res_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        run_div(100, 7, 1'b0, "d100_7");

        // Extra shifts after completion must not disturb the result.
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 8'd0, 8'd0);
            check_val("extra.max",       32'(max),       32'd0);
            check_val("extra.quotient",  32'(quotient),  32'd14);
            check_val("extra.remainder", 32'(remainder), 32'd2);
        end

        run_div(255, 1, 1'b0, "d255_1");
        run_div(5, 9, 1'b0, "d5_9");
        run_div(37, 0, 1'b0, "d37_0");

        // Restart with new operands part-way through a division.
        cyc(1'b1, 1'b0, 1'b1, 8'd200, 8'd3);
        repeat (4) cyc(1'b0, 1'b1, 1'b1, 8'd0, 8'd0);
        run_div(50, 6, 1'b0, "restart50_6");

        // Load and shift together: only the load acts.
        run_div(77, 5, 1'b1, "ldshift77_5");

        // Synchronous clear right after load holds the operands and count.
        cyc(1'b1, 1'b0, 1'b1, 8'd123, 8'd10);
        repeat (2) cyc(1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
        check_val("prst.quotient_held", 32'(quotient), 32'd123);
        for (int i = 0; i < N; i++) begin
            check_val("prst.max", 32'(max), (i == N - 1) ? 32'd1 : 32'd0);
            cyc(1'b0, 1'b1, 1'b1, 8'd0, 8'd0);
        end
        check_val("prst.quotient",  32'(quotient),  32'd12);
        check_val("prst.remainder", 32'(remainder), 32'd3);

        // Random operands, including occasional zero divisors.
        for (int k = 0; k < 30; k++) begin
            a = int'($urandom_range(0, 255));
            b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
            run_div(a, b, 1'b0, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_div_datapath
`default_nettype wire
